register_bank_mp: RTL

Parametrised multi-read-port register bank with write-to-read bypass and a per-register pending-write scoreboard. It replaces the single-write/dual-read bank in the decode stage. Decode reads any NUM_READ operands per cycle and gets per-operand ready flags for hazard stall logic. Issue marks a destination pending; writeback stores data and clears the pending mark.

---
 rtl/register_bank_mp.sv | 91 +++++++++
 1 files changed

// File: rtl/register_bank_mp.sv
// Multi-read-port register bank with write-to-read bypass and a per-register pending-write scoreboard.
// Optional hard-wired zero register selected by defining ZERO_REGISTER_EN.
module register_bank_mp #(
    parameter int unsigned REGISTER_SIZE = 32,
    parameter int unsigned ADDRESS_SIZE  = 5,
    parameter int unsigned NUM_READ      = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              write,
    input  logic [ADDRESS_SIZE-1:0]           addr_in,
    input  logic [REGISTER_SIZE-1:0]          data_in,
    input  logic                              issue,
    input  logic [ADDRESS_SIZE-1:0]           issue_addr,
    input  logic [NUM_READ*ADDRESS_SIZE-1:0]  addr_out,
    output logic [NUM_READ*REGISTER_SIZE-1:0] data_out,
    output logic [NUM_READ-1:0]               ready,
    output logic [ADDRESS_SIZE:0]             busy_count
);

    localparam int unsigned NUM_REGS = 1 << ADDRESS_SIZE;
    localparam int unsigned CNT_W    = ADDRESS_SIZE + 1;
`ifdef ZERO_REGISTER_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic [REGISTER_SIZE-1:0] regs_q [NUM_REGS];
    logic [REGISTER_SIZE-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]      busy_q;
    logic [NUM_REGS-1:0]      busy_d;
    logic [CNT_W-1:0]         count_q;
    logic [CNT_W-1:0]         count_d;
    logic                     wr_en;
    logic                     iss_en;

    // Register 0 swallows writes and claims when it is hard-wired to zero.
    always_comb begin
        wr_en  = write && !(ZERO_EN && (addr_in == '0));
        iss_en = issue && !(ZERO_EN && (issue_addr == '0));
    end

    // Next state: write clears the pending mark, then a claim sets it, so a same-register claim wins.
    always_comb begin
        regs_d  = regs_q;
        busy_d  = busy_q;
        count_d = '0;
        if (wr_en) begin
            regs_d[addr_in] = data_in;
            busy_d[addr_in] = 1'b0;
        end
        if (iss_en) begin
            busy_d[issue_addr] = 1'b1;
        end
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            count_d = count_d + CNT_W'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            regs_q  <= '{default: '0};
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            regs_q  <= regs_d;
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    // Combinational read ports; writeback data forwards to matching ports in the same cycle.
    always_comb begin : read_ports
        logic [ADDRESS_SIZE-1:0] ra;
        logic                    byp;
        data_out = '0;
        ready    = '0;
        ra       = '0;
        byp      = 1'b0;
        for (int k = 0; k < int'(NUM_READ); k++) begin
            ra  = addr_out[k*ADDRESS_SIZE +: ADDRESS_SIZE];
            byp = wr_en && (addr_in == ra);
            data_out[k*REGISTER_SIZE +: REGISTER_SIZE] = byp ? data_in : regs_q[ra];
            ready[k] = byp || !busy_q[ra];
        end
    end

    assign busy_count = count_q;

endmodule
